// File: rtl/nn_layer_sequencer_pkg.sv
// nn_ctrl_pkg: shared definitions for the layer sequencer slice.
//   - ARCH_W           : width of one net_arch word (neuron count of a layer)
//   - ARCH_MAX_LAYERS  : largest layer count the arch_word helper can index
//   - ST_*             : sequencer state encoding
//   - arch_word()      : extract the neuron count of layer k from a net_arch vector
package nn_ctrl_pkg;

    localparam int ARCH_W          = 32;
    localparam int ARCH_MAX_LAYERS = 16;

    typedef logic [ARCH_W*ARCH_MAX_LAYERS-1:0] arch_vec_t;

    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_SEED  = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_MUL   = 3'd4;
    localparam logic [2:0] ST_ADD   = 3'd5;
    localparam logic [2:0] ST_LATCH = 3'd6;
    localparam logic [2:0] ST_FIN   = 3'd7;

    // Callers widen their NR_LAYERS-word vector to arch_vec_t first, so one
    // helper serves every layer count. Out-of-range k reads as zero.
    function automatic logic [ARCH_W-1:0] arch_word(input arch_vec_t arch,
                                                    input int unsigned k);
        if (k < ARCH_MAX_LAYERS)
            return arch[k*ARCH_W +: ARCH_W];
        return '0;
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if: handshake bundle between the layer sequencer and the
// feed-forward datapath (weight storage, multiplier, adder, data/result regs).
//   master (sequencer): drives load_req, mul_start, l_cnt, m_cnt, sel_input,
//                       data_we, result_we, layer_idx; receives load_ack,
//                       mul_done, add_done.
//   slave  (datapath) : the mirror image.
interface nn_layer_sequencer_if;
    import nn_ctrl_pkg::*;

    logic              load_req;
    logic              load_ack;
    logic              mul_start;
    logic              mul_done;
    logic              add_done;
    logic [ARCH_W-1:0] l_cnt;
    logic [ARCH_W-1:0] m_cnt;
    logic              sel_input;
    logic              data_we;
    logic              result_we;
    logic [ARCH_W-1:0] layer_idx;

    modport master (
        output load_req, mul_start, l_cnt, m_cnt, sel_input, data_we,
               result_we, layer_idx,
        input  load_ack, mul_done, add_done
    );

    modport slave (
        input  load_req, mul_start, l_cnt, m_cnt, sel_input, data_we,
               result_we, layer_idx,
        output load_ack, mul_done, add_done
    );

endinterface

// File: rtl/nn_layer_sequencer_checker.sv
// nn_arch_checker: combinational legality check of a network description.
//   net_arch : NR_LAYERS words of ARCH_W bits, layer k in [ARCH_W*k +: ARCH_W]
//   ok       : 1 when every layer has 1..MAXNEURONS neurons, every layer that
//              feeds another has at most MAXWEIGHTS neurons, and the network
//              input fits a weight row (INPUTSIZE <= MAXWEIGHTS).
module nn_arch_checker
    import nn_ctrl_pkg::*;
#(
    parameter int NR_LAYERS  = 2,
    parameter int INPUTSIZE  = 4,
    parameter int MAXNEURONS = 10,
    parameter int MAXWEIGHTS = 4
) (
    input  logic [ARCH_W*NR_LAYERS-1:0] net_arch,
    output logic                        ok
);

    arch_vec_t arch;
    assign arch = arch_vec_t'(net_arch);

    always_comb begin
        ok = (INPUTSIZE <= MAXWEIGHTS);
        for (int unsigned k = 0; k < NR_LAYERS; k++) begin
            if (arch_word(arch, k) == '0 ||
                arch_word(arch, k) > ARCH_W'(MAXNEURONS))
                ok = 1'b0;
            // previous layer's outputs become this layer's weight row
            if (k > 0 && arch_word(arch, k - 1) > ARCH_W'(MAXWEIGHTS))
                ok = 1'b0;
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: control FSM for the layer-by-layer feed-forward pass
// (multiply -> vector add -> activation), one layer at a time.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle pulse, accepted only in IDLE
//   net_arch  : neuron count per layer, layer k in [32k +: 32]
//   dp        : datapath handshake bundle (master side)
//   busy      : high in every state but IDLE
//   done      : one-cycle pulse after the final layer's result is written
//   error     : sticky illegal-architecture flag, cleared by the next start
module nn_layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int NR_LAYERS  = 2,
    parameter int INPUTSIZE  = 4,
    parameter int MAXNEURONS = 10,
    parameter int MAXWEIGHTS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ARCH_W*NR_LAYERS-1:0] net_arch,
    nn_layer_sequencer_if.master        dp,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    state_t            state;
    logic [ARCH_W-1:0] layer_idx;
    logic [ARCH_W-1:0] l_cnt;
    logic [ARCH_W-1:0] m_cnt;
    logic              mul_first;   // first cycle of MUL: launch pulse
    logic              add_seen;    // add_done arrived together with mul_done
    logic              arch_ok;
    logic              last_layer;
    arch_vec_t         arch;

    assign arch       = arch_vec_t'(net_arch);
    assign last_layer = (layer_idx == ARCH_W'(NR_LAYERS - 1));

    nn_arch_checker #(
        .NR_LAYERS (NR_LAYERS),
        .INPUTSIZE (INPUTSIZE),
        .MAXNEURONS(MAXNEURONS),
        .MAXWEIGHTS(MAXWEIGHTS)
    ) u_checker (
        .net_arch(net_arch),
        .ok      (arch_ok)
    );

    // Strobes are decoded from state so an asynchronous reset zeroes them at once.
    assign dp.load_req  = (state == ST_LOAD);
    assign dp.mul_start = (state == ST_MUL) && mul_first;
    assign dp.sel_input = (state == ST_SEED);
    assign dp.data_we   = (state == ST_SEED) || ((state == ST_LATCH) && !last_layer);
    assign dp.result_we = (state == ST_FIN);
    assign dp.l_cnt     = l_cnt;
    assign dp.m_cnt     = m_cnt;
    assign dp.layer_idx = layer_idx;
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            layer_idx <= '0;
            l_cnt     <= '0;
            m_cnt     <= '0;
            mul_first <= 1'b0;
            add_seen  <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_CHECK;
                        error     <= 1'b0;
                        layer_idx <= '0;
                        m_cnt     <= ARCH_W'(INPUTSIZE);
                        mul_first <= 1'b0;
                        add_seen  <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (arch_ok) begin
                        state <= ST_SEED;
                    end else begin
                        error <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_SEED: begin
                    // l_cnt must be valid from the first LOAD cycle
                    l_cnt <= arch_word(arch, 0);
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (dp.load_ack) begin
                        state     <= ST_MUL;
                        mul_first <= 1'b1;
                    end
                end
                ST_MUL: begin
                    mul_first <= 1'b0;
                    if (dp.mul_done) begin
                        state    <= ST_ADD;
                        add_seen <= dp.add_done;
                    end
                end
                ST_ADD: begin
                    if (dp.add_done || add_seen) begin
                        state    <= ST_LATCH;
                        add_seen <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    if (last_layer) begin
                        state <= ST_FIN;
                    end else begin
                        // this layer's outputs are the next layer's inputs
                        m_cnt     <= l_cnt;
                        l_cnt     <= arch_word(arch, layer_idx + 32'd1);
                        layer_idx <= layer_idx + 32'd1;
                        state     <= ST_LOAD;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Cycle-accurate control FSM for the layer-by-layer feed-forward datapath: MatrixMultiplicationFlex, then VectorAdditionFlex, then the per-neuron activation bank.
- Replaces sensitivity-list sequencing with explicit handshakes.
- Per layer it requests weight/bias loading, supplies l/m dimensions, launches the multiply, waits for the add, and latches the activation vector as the next layer's input.
- Raises done after the final layer.

Parameters:
- NR_LAYERS, 2, number of layers described by net_arch
- INPUTSIZE, 4, element count of the network input vector
- MAXNEURONS, 10, maximum neurons per layer (datapath buffer depth)
- MAXWEIGHTS, 4, maximum inputs per neuron (datapath weight-row depth)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse; begins a network pass when idle
- net_arch  input  32*NR_LAYERS  neuron count of layer k in bits [32k +: 32]
- load_req  output  1  held high until load_ack; load layer_idx weights/biases
- load_ack  input  1  one-cycle pulse; storage for layer_idx is valid
- mul_start  output  1  one-cycle launch pulse to the multiplier
- mul_done  input  1  one-cycle pulse from the multiplier
- add_done  input  1  one-cycle pulse from the vector adder
- l_cnt  output  32  neuron count of the current layer
- m_cnt  output  32  input count of the current layer
- sel_input  output  1  1: data_store source is inputdata; 0: activation feedback
- data_we  output  1  one-cycle write enable for data_store
- result_we  output  1  one-cycle write enable for the network result register
- layer_idx  output  32  index of the layer in progress
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on successful completion
- error  output  1  sticky until next accepted start; illegal architecture

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE; all outputs 0; an in-flight datapath operation is abandoned; late acks/dones are ignored in IDLE.
- States: IDLE, CHECK, SEED, LOAD, MUL, ADD, LATCH, FIN.
- IDLE: start=1 -> CHECK. Clear error, layer_idx=0, m_cnt=INPUTSIZE.
- IDLE: start while busy is ignored; no queuing.
- CHECK (1 cycle): every layer must satisfy 1 <= net_arch[k] <= MAXNEURONS. For k>0, also net_arch[k-1] <= MAXWEIGHTS. Require INPUTSIZE <= MAXWEIGHTS.
  - Any violation: error=1 -> IDLE, no done.
  - Otherwise -> SEED.
- SEED (1 cycle): sel_input=1, data_we=1 -> LOAD.
- LOAD: l_cnt=net_arch[layer_idx]; load_req=1; on load_ack -> MUL (load_req drops the same edge).
- MUL:
  - mul_start pulses in the first cycle of MUL only.
  - Wait for mul_done -> ADD.
  - If add_done coincides with mul_done, register it and skip the wait in ADD.
- ADD: wait for add_done -> LATCH.
- The activation is combinational, so currentresult is valid the cycle after add_done.
- LATCH (1 cycle), sel_input=0:
  - If layer_idx==NR_LAYERS-1 -> FIN.
  - Else: data_we=1; m_cnt<=l_cnt; layer_idx++ -> LOAD.
- FIN (1 cycle): result_we=1, done=1 -> IDLE. layer_idx, l_cnt, m_cnt hold their last values until the next start.
- Stray mul_done/add_done/load_ack in a non-waiting state are ignored.
- Latency with zero-wait acks: 2 + 4*NR_LAYERS cycles from start to done, plus external waits.

Decomposition:
- Shared package nn_ctrl_pkg: state enum, ARCH_W=32 word-width constant, helper function arch_word(net_arch,k).
- Sub-module nn_arch_checker: combinational legality check of net_arch/INPUTSIZE against MAXNEURONS/MAXWEIGHTS, returning ok.
- The FSM stays in nn_layer_sequencer.

Test Plan:
- Nominal, net_arch={10,4}, acks 1 cycle after each request:
  - layer 0: l=4, m=4
  - layer 1: l=10, m=4
  - data_we pulses exactly twice; result_we and done pulse once; busy drops the cycle after done.
- Illegal architecture, layer1=11 with MAXNEURONS=10: error=1 two cycles after start, no load_req, busy low; the next legal start clears error.
- Same-cycle mul_done and add_done: sequencer reaches LATCH without waiting in ADD; total latency equals nominal minus the ADD wait.
- Back-pressure, load_ack delayed 7 cycles: load_req held for 7 cycles; mul_start pulses once, the cycle after load_ack.
- Reset mid-operation:
  - Assert rst while in MUL with layer_idx=1: all outputs 0 immediately.
  - A subsequent mul_done causes no transition.
  - A fresh start runs the full pass correctly.
- Start while busy: extra start pulses during ADD are ignored; exactly one done per accepted start.
